// File: rtl/page_qin_multi.sv
// rtl/page_qin_multi.sv - bank of NCH independent FWFT stream FIFOs with slack back-pressure
// Each channel: circular buffer, occupancy/eos counters, sticky overflow, sync flush.
module page_qin_multi #(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int SLACK = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH*DW-1:0]     qin_d,
  input  logic [NCH-1:0]        qin_e,
  input  logic [NCH-1:0]        qin_v,
  output logic [NCH-1:0]        qin_b,
  output logic [NCH*DW-1:0]     qout_d,
  output logic [NCH-1:0]        qout_e,
  output logic [NCH-1:0]        qout_v,
  input  logic [NCH-1:0]        qout_b,
  input  logic [NCH-1:0]        clear,
  output logic [NCH*(AW+1)-1:0] count,
  output logic [NCH*(AW+1)-1:0] eos_pend,
  output logic [NCH-1:0]        overflow
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] SLACK_W = (AW+1)'(SLACK);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW:0]   mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d, eos_q, eos_d;
    logic          ovf_q, ovf_d;
    logic          full, rd, wr, wr_mem, head_e;
    logic [AW:0]   free;

    always_comb begin
      full   = (count_q == DEPTH_W);
      head_e = mem_q[rptr_q][0];
      rd     = (count_q != '0) && !qout_b[c];
      // A read in the same cycle frees the slot, so a full queue still accepts.
      wr     = qin_v[c] && (!full || rd);
      wr_mem = wr && !clear[c] && !reset;
      rptr_d = rptr_q + AW'(rd);
      wptr_d = wptr_q + AW'(wr);
      count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
      eos_d   = eos_q + (AW+1)'(wr && qin_e[c]) - (AW+1)'(rd && head_e);
      ovf_d   = ovf_q || (qin_v[c] && full && !rd);
      if (clear[c]) begin
        rptr_d  = '0;
        wptr_d  = '0;
        count_d = '0;
        eos_d   = '0;
        ovf_d   = 1'b0;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
        eos_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        rptr_q  <= rptr_d;
        wptr_q  <= wptr_d;
        count_q <= count_d;
        eos_q   <= eos_d;
        ovf_q   <= ovf_d;
      end
    end

    always_ff @(posedge clock) begin
      if (wr_mem) mem_q[wptr_q] <= {qin_d[c*DW +: DW], qin_e[c]};
    end

    assign free                      = DEPTH_W - count_q;
    assign qin_b[c]                  = (free <= SLACK_W);
    assign qout_v[c]                 = (count_q != '0);
    assign qout_d[c*DW +: DW]        = mem_q[rptr_q][DW:1];
    assign qout_e[c]                 = head_e;
    assign count[c*(AW+1) +: AW+1]   = count_q;
    assign eos_pend[c*(AW+1) +: AW+1] = eos_q;
    assign overflow[c]               = ovf_q;
  end

endmodule
